// File: rtl/display_arbiter_if.sv
// ---------------------------------------------------------------------------
// display_arbiter_if
// Purpose : groups the time-source, control and display-pin signals of the
//           display arbiter into one bundle.
// Signals : dip_sw      [2:0]  source select switches (bit2 sw, bit1 tmr, bit0 clk)
//           timer_done         timer expiry level
//           key_any            OR of all keypad lines
//           clk_digits  [23:0] clock BCD digits  {h10,h1,m10,m1,s10,s1}
//           tmr_digits  [23:0] timer BCD digits  (same packing)
//           sw_digits   [23:0] stopwatch BCD digits (same packing)
//           seg_data    [7:0]  segments a..g,dp active high (bit7=a, bit0=dp)
//           seg_com     [7:0]  digit enables, active low
//           active_src  [1:0]  source of the frame being shown
//           buzzer             notification tone enable
// Modports: master = board / time-keeping side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface display_arbiter_if;
    logic [2:0]  dip_sw;
    logic        timer_done;
    logic        key_any;
    logic [23:0] clk_digits;
    logic [23:0] tmr_digits;
    logic [23:0] sw_digits;
    logic [7:0]  seg_data;
    logic [7:0]  seg_com;
    logic [1:0]  active_src;
    logic        buzzer;

    modport master (
        output dip_sw, timer_done, key_any, clk_digits, tmr_digits, sw_digits,
        input  seg_data, seg_com, active_src, buzzer
    );

    modport slave (
        input  dip_sw, timer_done, key_any, clk_digits, tmr_digits, sw_digits,
        output seg_data, seg_com, active_src, buzzer
    );
endinterface

// File: rtl/display_arbiter.sv
// ---------------------------------------------------------------------------
// display_arbiter
// Purpose : shares one 6-digit multiplexed 7-segment display between the
//           clock, countdown timer and stopwatch. Owns the scan counter and
//           segment decode, debounces the source-select switches, switches
//           source only at frame boundaries, and overrides the display with a
//           blinking timer-expiry notification that also drives the buzzer.
// Ports   : clk  - system clock (1 kHz)
//           rst  - asynchronous active-high reset
//           bus  - display_arbiter_if.slave (inputs: dip_sw, timer_done,
//                  key_any, *_digits; outputs: seg_data, seg_com,
//                  active_src, buzzer; all outputs registered)
// ---------------------------------------------------------------------------
module display_arbiter #(
    parameter int SETTLE        = 20,
    parameter int BLINK_HALF    = 500,
    parameter int NOTIFY_CYCLES = 5000
) (
    input  logic                clk,
    input  logic                rst,
    display_arbiter_if.slave    bus
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int BW = $clog2(2 * BLINK_HALF);
    localparam int NW = $clog2(NOTIFY_CYCLES);

    typedef enum logic {
        ST_NORMAL,
        ST_NOTIFY
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t          r_state;
    logic [2:0]      r_scan_cnt;
    logic [SW-1:0]   r_settle_cnt;
    logic [2:0]      r_cand;
    logic [1:0]      r_settled_sel;
    logic [23:0]     r_snapshot;
    logic [1:0]      r_active_src;
    logic [BW-1:0]   r_blink_cnt;
    logic [NW-1:0]   r_notify_cnt;
    logic            r_td_prev;
    logic            r_key_prev;
    logic [7:0]      r_seg_data;
    logic [7:0]      r_seg_com;
    logic            r_buzzer;

    // -----------------------------------------------------------------------
    // Wires
    // -----------------------------------------------------------------------
    logic [3:0]      w_snap_digit [6];
    logic [7:0]      w_scan_com;
    logic [3:0]      w_scan_dig;
    logic            w_scan_act;
    logic [1:0]      w_frame_src;
    logic [23:0]     w_frame_digits;
    logic            w_td_rise;
    logic            w_key_rise;
    logic            w_enter;
    logic            w_exit;
    logic            w_stay;
    logic [BW-1:0]   w_blink_inc;
    logic            w_on_next;
    logic            w_blank_next;
    logic [7:0]      w_seg_next;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        s = 8'h00;
        case (d)
            4'd0: s = 8'hFC;
            4'd1: s = 8'h60;
            4'd2: s = 8'hDA;
            4'd3: s = 8'hF2;
            4'd4: s = 8'h66;
            4'd5: s = 8'hB6;
            4'd6: s = 8'hBE;
            4'd7: s = 8'hE0;
            4'd8: s = 8'hFE;
            4'd9: s = 8'hF6;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Highest set switch wins; no switch set falls back to the clock.
    function automatic logic [1:0] sel_priority(input logic [2:0] sw);
        logic [1:0] p;
        p = 2'd0;
        if (sw[2])      p = 2'd2;
        else if (sw[1]) p = 2'd1;
        else            p = 2'd0;
        return p;
    endfunction

    // Snapshot digit gi: gi=0 is h_ten (MSB nibble), gi=5 is s_one.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            assign w_snap_digit[gi] = r_snapshot[23 - 4*gi -: 4];
        end
    endgenerate

    always_comb begin
        w_scan_com = 8'hFF;
        w_scan_dig = 4'h0;
        w_scan_act = 1'b0;
        case (r_scan_cnt)
            3'd0: begin w_scan_com = 8'h7F; w_scan_dig = w_snap_digit[0]; w_scan_act = 1'b1; end
            3'd1: begin w_scan_com = 8'hBF; w_scan_dig = w_snap_digit[1]; w_scan_act = 1'b1; end
            3'd2: begin w_scan_com = 8'hDF; w_scan_dig = w_snap_digit[2]; w_scan_act = 1'b1; end
            3'd3: begin w_scan_com = 8'hEF; w_scan_dig = w_snap_digit[3]; w_scan_act = 1'b1; end
            3'd4: begin w_scan_com = 8'hF7; w_scan_dig = w_snap_digit[4]; w_scan_act = 1'b1; end
            3'd5: begin w_scan_com = 8'hFB; w_scan_dig = w_snap_digit[5]; w_scan_act = 1'b1; end
            default: begin w_scan_com = 8'hFF; w_scan_dig = 4'h0; w_scan_act = 1'b0; end
        endcase
    end

    // A notification forces the timer onto the display for the next frame.
    assign w_frame_src = (r_state == ST_NOTIFY) ? 2'd1 : r_settled_sel;

    always_comb begin
        w_frame_digits = bus.sw_digits;
        case (w_frame_src)
            2'd0:    w_frame_digits = bus.clk_digits;
            2'd1:    w_frame_digits = bus.tmr_digits;
            default: w_frame_digits = bus.sw_digits;
        endcase
    end

    assign w_td_rise  = bus.timer_done & ~r_td_prev;
    assign w_key_rise = bus.key_any    & ~r_key_prev;

    assign w_enter = (r_state == ST_NORMAL) && w_td_rise;
    assign w_exit  = (r_state == ST_NOTIFY) &&
                     ((r_notify_cnt == NW'(NOTIFY_CYCLES - 1)) || w_key_rise);
    assign w_stay  = (r_state == ST_NOTIFY) && !w_exit;

    assign w_blink_inc = (r_blink_cnt == BW'(2 * BLINK_HALF - 1)) ? '0
                                                                  : r_blink_cnt + 1'b1;

    // Buzzer and blanking follow the state/blink values being loaded this
    // edge, so both outputs line up with the registered FSM state.
    assign w_on_next    = w_enter || (w_stay && (w_blink_inc <  BW'(BLINK_HALF)));
    assign w_blank_next = w_stay && (w_blink_inc >= BW'(BLINK_HALF));

    assign w_seg_next = (w_scan_act && !w_blank_next) ? seg_decode(w_scan_dig) : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_NORMAL;
            r_scan_cnt    <= 3'd0;
            r_settle_cnt  <= '0;
            r_cand        <= 3'b000;
            r_settled_sel <= 2'd0;
            r_snapshot    <= 24'h000000;
            r_active_src  <= 2'd0;
            r_blink_cnt   <= '0;
            r_notify_cnt  <= '0;
            // Edge detectors start "high" so a level already asserted when
            // reset releases is not mistaken for a fresh rising edge.
            r_td_prev     <= 1'b1;
            r_key_prev    <= 1'b1;
            r_seg_data    <= 8'h00;
            r_seg_com     <= 8'hFF;
            r_buzzer      <= 1'b0;
        end else begin
            r_scan_cnt <= r_scan_cnt + 3'd1;
            r_seg_com  <= w_scan_com;
            r_seg_data <= w_seg_next;
            r_buzzer   <= w_on_next;
            r_td_prev  <= bus.timer_done;
            r_key_prev <= bus.key_any;

            // Selection debounce: restart on any switch movement.
            if (bus.dip_sw != r_cand) begin
                r_cand       <= bus.dip_sw;
                r_settle_cnt <= '0;
            end else if (r_settle_cnt == SW'(SETTLE - 1)) begin
                r_settled_sel <= sel_priority(r_cand);
            end else begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end

            // Frame boundary: source and digits are frozen for the whole frame.
            if (r_scan_cnt == 3'd7) begin
                r_active_src <= w_frame_src;
                r_snapshot   <= w_frame_digits;
            end

            case (r_state)
                ST_NORMAL: begin
                    if (w_enter) begin
                        r_state      <= ST_NOTIFY;
                        r_blink_cnt  <= '0;
                        r_notify_cnt <= '0;
                    end
                end
                ST_NOTIFY: begin
                    if (w_exit) begin
                        r_state <= ST_NORMAL;
                    end else begin
                        r_blink_cnt  <= w_blink_inc;
                        r_notify_cnt <= r_notify_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.seg_data   = r_seg_data;
    assign bus.seg_com    = r_seg_com;
    assign bus.active_src = r_active_src;
    assign bus.buzzer     = r_buzzer;

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 6-digit multiplexed 7-segment display among three BCD time sources: clock, countdown timer and stopwatch.
- Selects the displayed source from debounced DIP switches and commits source changes only at frame boundaries, so no frame mixes sources.
- Preempts the display with a blinking timer-expiry notification and drives the buzzer.
- Sits between the time-keeping blocks and the board seg_data/seg_com pins; it owns the scan counter and the segment decode.

Parameters:
- SETTLE, 20: cycles dip_sw must stay unchanged before a new selection is accepted.
- BLINK_HALF, 500: cycles per blink phase (on or off) during notification (1 kHz clk gives 0.5 s).
- NOTIFY_CYCLES, 5000: maximum notification length in cycles.

Ports:
- clk  in  1  1 kHz system clock
- rst  in  1  asynchronous, active-high reset
- dip_sw  in  3  bit2 stopwatch, bit1 timer, bit0 clock select
- timer_done  in  1  level from timer; rising edge triggers notification
- key_any  in  1  OR of all keypad lines; rising edge acknowledges notification
- clk_digits  in  24  {h_ten,h_one,m_ten,m_one,s_ten,s_one}, 4-bit BCD each
- tmr_digits  in  24  same packing
- sw_digits  in  24  same packing
- seg_data  out  8  segments, active high, bit7=a … bit1=g, bit0=dp (always 0)
- seg_com  out  8  digit enables, active low
- active_src  out  2  0 clock, 1 timer, 2 stopwatch: source of the current frame
- buzzer  out  1  high during notification on-phase

Behaviour:
- Reset values: seg_com=8'hFF, seg_data=8'h00, active_src=0, buzzer=0, state NORMAL, all counters 0, settled selection=clock, frame snapshot=0.
- Scan:
  - 3-bit scan_cnt increments every clk and wraps 7→0.
  - Outputs are registered, so output reflects the scan_cnt value of the previous cycle.
  - scan_cnt 0..5 drive seg_com 7F, BF, DF, EF, F7, FB with digits h_ten, h_one, m_ten, m_one, s_ten, s_one.
  - scan_cnt 6 and 7 drive seg_com=FF and seg_data=00.
- Decode:
  - 0:FC, 1:60, 2:DA, 3:F2, 4:66, 5:B6, 6:BE, 7:E0, 8:FE, 9:F6.
  - Nibbles 10..15 decode to 00.
- Selection debounce:
  - When raw dip_sw differs from the candidate: candidate<=dip_sw and settle_cnt<=0.
  - Otherwise, when settle_cnt==SETTLE-1: settled_sel<=priority(candidate); otherwise settle_cnt increments.
  - Priority: bit2 > bit1 > bit0; 3'b000 selects clock.
- Frame boundary (scan_cnt==7):
  - frame_src<=(state==NOTIFY)?timer:settled_sel.
  - The 24-bit snapshot of the frame_src digits is captured.
  - active_src<=frame_src.
  - Digits shown during scan 0..5 come only from the snapshot.
- FSM NORMAL → NOTIFY:
  - Trigger is the rising edge of timer_done (registered previous value).
  - On entry: blink_cnt<=0 and notify_cnt<=0.
  - A timer_done level held high never re-triggers.
- FSM NOTIFY → NORMAL, on whichever comes first:
  - notify_cnt reaching NOTIFY_CYCLES-1.
  - A key_any rising edge detected while already in NOTIFY.
  - key_any rising in the same cycle as entry does not acknowledge.
- Blink:
  - blink_cnt counts 0..2*BLINK_HALF-1 and wraps.
  - On-phase is blink_cnt<BLINK_HALF.
  - In the off-phase seg_data is forced to 00; seg_com keeps scanning.
  - buzzer = (state==NOTIFY) && on-phase, registered.
- dip_sw changes during NOTIFY are still debounced; the new selection is shown from the first frame boundary after exit.
- A timer_done rising edge during NOTIFY is ignored; counters are not restarted.
- rst asserted mid-frame or mid-NOTIFY forces reset values immediately. The first scan output after release is digit 0.

Test Plan:
- Reset release, dip_sw=000, clk_digits=0x123456 → the cycle sequence seg_com 7F,BF,DF,EF,F7,FB,FF,FF repeats with seg_data 60,DA,F2,66,B6,BE,00,00; active_src=0.
- dip_sw 000→010 held 25 cycles, tmr_digits=0x000930 → active_src=1 only at the frame boundary after cycle 20 of stability. A 10-cycle glitch to 100 leaves the selection unchanged.
- dip_sw=111 → stopwatch selected (active_src=2). Changing sw_digits mid-frame does not alter the current frame.
- timer_done 0→1 with dip_sw=001:
  - active_src=1 from the next boundary.
  - buzzer high for 500 cycles, then low 500 cycles, seg_data=00 during the low phase.
  - Exit after 5000 cycles, then active_src returns to 0.
- In NOTIFY at cycle 1200, key_any pulse → NORMAL and buzzer=0 the next cycle. key_any already high at the entry cycle does not acknowledge.
- rst pulse during NOTIFY on-phase → seg_com=FF, buzzer=0, active_src=0 immediately. timer_done held high after reset with no new edge → no notification.
